// File: rtl/mvu_simd_dot.sv
`default_nettype none
// ============================================================================
// mvu_simd_dot : SIMD multiply + adder-tree dot-product slice with row
//                accumulation (integer, XNOR-popcount and binary-weight modes)
// Revision     : 1.0  initial release
// ============================================================================
module mvu_simd_dot #(
  parameter int SIMD       = 4,
  parameter int TI         = 4,
  parameter int TW         = 4,
  parameter int TO         = 16,
  parameter int OP_MODE    = 0,
  parameter int SIGNED_ACT = 1,
  parameter int SIGNED_WGT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_v,
  input  logic                 in_last,
  input  logic [SIMD*TI-1:0]   in_act,
  input  logic [SIMD*TW-1:0]   in_wgt,
  output logic                 out_v,
  output logic [TO-1:0]        out
);

  localparam logic [TO-1:0] c_zero = '0;

  logic [TO-1:0] w_prod [SIMD];
  logic [TO-1:0] r_prod [SIMD];
  logic          r_v1;
  logic          r_last1;
  logic [TO-1:0] r_acc;
  logic          r_first;
  logic [TO-1:0] w_sum;
  logic [TO-1:0] w_total;

  for (genvar i = 0; i < SIMD; i++) begin : g_lane
    logic [TI-1:0] w_a;
    logic [TW-1:0] w_w;
    assign w_a = in_act[i*TI +: TI];
    assign w_w = in_wgt[i*TW +: TW];

    if (OP_MODE == 1) begin : g_xnor
      assign w_prod[i] = {{(TO-1){1'b0}}, ~(w_a[0] ^ w_w[0])};
    end else begin : g_arith
      logic [TO-1:0] w_a_ext;
      if (SIGNED_ACT != 0) begin : g_act_s
        assign w_a_ext = {{(TO-TI){w_a[TI-1]}}, w_a};
      end else begin : g_act_u
        assign w_a_ext = {{(TO-TI){1'b0}}, w_a};
      end

      if (OP_MODE == 2) begin : g_bin
        assign w_prod[i] = w_w[0] ? w_a_ext : (c_zero - w_a_ext);
      end else begin : g_mul
        logic [TO-1:0] w_w_ext;
        if (SIGNED_WGT != 0) begin : g_wgt_s
          assign w_w_ext = {{(TO-TW){w_w[TW-1]}}, w_w};
        end else begin : g_wgt_u
          assign w_w_ext = {{(TO-TW){1'b0}}, w_w};
        end
        // Both operands pre-extended to TO, so the low TO bits of the
        // product are correct for any signedness mix.
        assign w_prod[i] = w_a_ext * w_w_ext;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < SIMD; i++) begin
      w_sum = w_sum + r_prod[i];
    end
  end

  assign w_total = (r_first ? c_zero : r_acc) + w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_acc   <= '0;
      r_first <= 1'b1;
      out_v   <= 1'b0;
      out     <= '0;
      for (int i = 0; i < SIMD; i++) begin
        r_prod[i] <= '0;
      end
    end else if (en) begin
      r_v1    <= in_v;
      r_last1 <= in_v & in_last;
      for (int i = 0; i < SIMD; i++) begin
        r_prod[i] <= w_prod[i];
      end

      out_v <= 1'b0;
      if (r_v1) begin
        if (r_last1) begin
          out     <= w_total;
          out_v   <= 1'b1;
          r_acc   <= '0;
          r_first <= 1'b1;
        end else begin
          r_acc   <= w_total;
          r_first <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvu_simd_dot.sv
`default_nettype none
// ============================================================================
// tb_mvu_simd_dot : directed + random bench for three mvu_simd_dot configs
// Revision        : 1.0  initial release
// ============================================================================
module tb_mvu_simd_dot;

  logic        clk = 1'b0;
  logic        rst, en, in_v, in_last;
  logic [15:0] a0, w0, a2;
  logic [7:0]  a1, w1;
  logic [3:0]  w2;
  logic        ov0, ov1, ov2;
  logic [15:0] o0, o1, o2;

  int total = 0;
  int bad   = 0;

  int          row_sum  [3];
  bit          pend     [3];
  logic [15:0] pend_val [3];
  bit          exp_v    [3];
  logic [15:0] exp_out  [3];

  always #5 clk = ~clk;

  mvu_simd_dot #(.SIMD(4), .TI(4), .TW(4), .TO(16), .OP_MODE(0),
                 .SIGNED_ACT(1), .SIGNED_WGT(1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .in_v(in_v), .in_last(in_last),
    .in_act(a0), .in_wgt(w0), .out_v(ov0), .out(o0));

  mvu_simd_dot #(.SIMD(8), .TI(1), .TW(1), .TO(16), .OP_MODE(1),
                 .SIGNED_ACT(0), .SIGNED_WGT(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .in_v(in_v), .in_last(in_last),
    .in_act(a1), .in_wgt(w1), .out_v(ov1), .out(o1));

  mvu_simd_dot #(.SIMD(4), .TI(4), .TW(1), .TO(16), .OP_MODE(2),
                 .SIGNED_ACT(1), .SIGNED_WGT(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .in_v(in_v), .in_last(in_last),
    .in_act(a2), .in_wgt(w2), .out_v(ov2), .out(o2));

  function automatic int sx4(logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  function automatic int dot0(logic [15:0] a, logic [15:0] w);
    int s = 0;
    for (int i = 0; i < 4; i++) s += sx4(a[i*4 +: 4]) * sx4(w[i*4 +: 4]);
    return s;
  endfunction

  function automatic int dot1(logic [7:0] a, logic [7:0] w);
    int s = 0;
    for (int i = 0; i < 8; i++) if (a[i] == w[i]) s++;
    return s;
  endfunction

  function automatic int dot2(logic [15:0] a, logic [3:0] w);
    int s = 0;
    for (int i = 0; i < 4; i++) s += w[i] ? sx4(a[i*4 +: 4]) : -sx4(a[i*4 +: 4]);
    return s;
  endfunction

  task automatic cmp(string tag, logic [15:0] obs, logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Row-level reference: a row's dot product appears one enabled edge after
  // its last beat is accepted, and out holds until the next completed row.
  task automatic model_update();
    int d [3];
    d[0] = dot0(a0, w0);
    d[1] = dot1(a1, w1);
    d[2] = dot2(a2, w2);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        row_sum[k] = 0;
        pend[k]    = 1'b0;
        exp_v[k]   = 1'b0;
        exp_out[k] = '0;
      end else if (en) begin
        exp_v[k] = pend[k];
        if (pend[k]) exp_out[k] = pend_val[k];
        pend[k] = 1'b0;
        if (in_v) begin
          row_sum[k] += d[k];
          if (in_last) begin
            pend[k]     = 1'b1;
            pend_val[k] = 16'(row_sum[k]);
            row_sum[k]  = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    cmp("d0_out_v", 16'(ov0), 16'(exp_v[0]));
    cmp("d0_out",   o0,       exp_out[0]);
    cmp("d1_out_v", 16'(ov1), 16'(exp_v[1]));
    cmp("d1_out",   o1,       exp_out[1]);
    cmp("d2_out_v", 16'(ov2), 16'(exp_v[2]));
    cmp("d2_out",   o2,       exp_out[2]);
  endtask

  task automatic step(bit r, bit e, bit v, bit l,
                      logic [15:0] sa0, logic [15:0] sw0,
                      logic [7:0]  sa1, logic [7:0]  sw1,
                      logic [15:0] sa2, logic [3:0]  sw2);
    rst = r; en = e; in_v = v; in_last = l;
    a0 = sa0; w0 = sw0; a1 = sa1; w1 = sw1; a2 = sa2; w2 = sw2;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      row_sum[k] = 0; pend[k] = 1'b0; pend_val[k] = '0;
      exp_v[k] = 1'b0; exp_out[k] = '0;
    end
    rst = 1'b1; en = 1'b1; in_v = 1'b0; in_last = 1'b0;
    a0 = '0; w0 = '0; a1 = '0; w1 = '0; a2 = '0; w2 = '0;

    step(1, 1, 0, 0, 16'h0, 16'h0, 8'h0, 8'h0, 16'h0, 4'h0);
    step(1, 1, 0, 0, 16'h0, 16'h0, 8'h0, 8'h0, 16'h0, 4'h0);
    cmp("reset_out", o0, 16'h0000);

    // Single-beat rows in every mode, then a back-to-back XNOR row.
    step(0, 1, 1, 1, 16'h4321, 16'h1111, 8'hAA, 8'hF0, 16'h15E3, 4'b1001);
    step(0, 1, 1, 1, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 16'h0000, 4'b0000);
    cmp("t1_d0_out", o0, 16'd10);
    cmp("t1_d0_v",   16'(ov0), 16'd1);
    cmp("t3_d1_out", o1, 16'd4);
    cmp("t4_d2_out", o2, 16'd1);

    // Two-beat signed row with extreme values.
    step(0, 1, 1, 0, 16'h0F78, 16'h5F87, 8'h00, 8'h00, 16'h0000, 4'b0000);
    cmp("t3_d1_b2b", o1, 16'd8);
    step(0, 1, 1, 1, 16'h1111, 16'hFFFF, 8'h00, 8'h00, 16'h0000, 4'b0000);
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 4'b0000);
    cmp("t2_d0_out", o0, 16'hFF8D);
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 4'b0000);

    // Binary-weight row split by bubbles.
    step(0, 1, 1, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h15E3, 4'b1001);
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h7777, 4'b0000);
    step(0, 1, 0, 1, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h7777, 4'b0000);
    step(0, 1, 1, 1, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h15E3, 4'b1001);
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 4'b0000);
    cmp("t4_d2_bubbles", o2, 16'd2);

    // Stall while a result is presented and a row is in flight.
    step(0, 1, 1, 1, 16'h4321, 16'h1111, 8'h00, 8'h00, 16'h0000, 4'b0000);
    step(0, 1, 1, 0, 16'h1111, 16'h1111, 8'h00, 8'h00, 16'h0000, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      step(0, 0, 1, 1, 16'h7777, 16'h7777, 8'hFF, 8'hFF, 16'h7777, 4'b1111);
      cmp("t5_stall_v",   16'(ov0), 16'd1);
      cmp("t5_stall_out", o0,       16'd10);
    end
    step(0, 1, 1, 1, 16'h1111, 16'h1111, 8'h00, 8'h00, 16'h0000, 4'b0000);
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 4'b0000);
    cmp("t5_resume_out", o0, 16'd8);

    // Reset mid-row, then a fresh row.
    step(0, 1, 1, 0, 16'h4321, 16'h1111, 8'hFF, 8'hFF, 16'h1111, 4'b1111);
    step(0, 1, 1, 0, 16'h4321, 16'h1111, 8'hFF, 8'hFF, 16'h1111, 4'b1111);
    step(1, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 4'b0000);
    step(0, 1, 1, 1, 16'h1111, 16'h2222, 8'h00, 8'h00, 16'h0000, 4'b0000);
    cmp("t6_no_v", 16'(ov0), 16'd0);
    step(0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 4'b0000);
    cmp("t6_fresh_out", o0, 16'd8);

    // Random traffic against the row-level reference.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
           ($urandom_range(3) != 0), ($urandom_range(2) == 0),
           16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
           16'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
